fetch_predict: RTL and testbench
================================

Name: fetch_predict

Overview:
- Dual-issue instruction fetch stage. Sits directly upstream of the decode stage.
- Holds the PC and presents two sequential instructions per cycle (instrF1, instrF2) with PCPlus4F and predict_takenF.
- Contains a 2-bit saturating branch history table (BHT) that predicts beq/bne.
- Applies redirects from decode: misprediction recovery and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- IDX_BITS, 6, BHT index width; BHT holds 2**IDX_BITS entries.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stallF  in  1  hold PC, outputs and BHT prediction path.
- imem_addr  out  32  word-aligned PC of slot 1 (slot 2 = imem_addr+4).
- imem_rd1, imem_rd2  in  32 each  combinational instruction memory data for slot 1 and slot 2.
- instrF1, instrF2  out  32 each  fetched instructions to decode.
- PCPlus4F  out  32  PC+4 of slot 1.
- predict_takenF  out  2  bit0 = slot 1, bit1 = slot 2.
- misspredict1, misspredict2  in  1 each  from decode.
- pcsrcD1, pcsrcD2  in  1 each  resolved branch outcome.
- branchD1, branchD2  in  2 each  nonzero = slot holds beq/bne.
- pcbranchD1, pcbranchD2, pcplus4D  in  32 each  decode targets.
- jumpD1, jumpD2  in  1 each  jump in decode slot.
- jumpdstD1, jumpdstD2  in  28 each  jump offset, already shifted by 2.
- stallD  in  1  decode stalled; redirects and BHT updates are ignored while high.

Behaviour:
- Reset (reset=0, async): PC=RESET_PC; all BHT counters = 2'b01 (weakly not-taken).
- Fetch datapath is combinational: imem_addr=PC; PCPlus4F=PC+4.
- Branch detect: opcode 000100 (beq) or 000101 (bne) in imem_rd1/imem_rd2.
- Prediction:
  - p1 = branch1 AND BHT[PC[IDX_BITS+1:2]][1].
  - p2 = branch2 AND BHT[(PC+4)[IDX_BITS+1:2]][1] AND !p1.
  - predict_takenF = {p2, p1}.
- Slot kill: if p1, instrF2 = 0 (nop). Otherwise instrF1/instrF2 = imem_rd1/imem_rd2.
- Predicted target for slot n = PC+4 + (signext(imm_n)<<2). Both slots use PC+4, matching the decode target adders.
- Next-PC priority at each posedge (highest first):
  1. misspredict1 && !stallD: PC = pcsrcD1 ? pcbranchD1 : pcplus4D.
  2. misspredict2 && !stallD: PC = pcsrcD2 ? pcbranchD2 : pcplus4D+4.
  3. jumpD1 && !stallD: PC = {pcplus4D[31:28], jumpdstD1}.
  4. jumpD2 && !stallD: PC = {pcplus4D[31:28], jumpdstD2}.
  5. stallF: PC unchanged.
  6. p1: slot 1 target.
  7. p2: slot 2 target.
  8. else PC+8.
- A redirect overrides stallF.
- BHT update, same edge, when !stallD:
  - For each slot with branchDn != 0, saturating update: increment if pcsrcDn, decrement otherwise.
  - Limits: 2'b11 +1 stays 2'b11; 2'b00 -1 stays 2'b00.
  - Index: slot 1 = (pcplus4D-4)[IDX_BITS+1:2]; slot 2 = pcplus4D[IDX_BITS+1:2].
  - If both slots map to the same index, the slot 2 update wins.
- Reads are combinational from current BHT state. A same-cycle update is not visible until the next cycle.
- PC wrap: arithmetic is modulo 2**32, no trap.
- Reset asserted mid-operation: PC and BHT are reset immediately. Outputs follow the RESET_PC fetch once reset deasserts.

Decomposition:
- Shared package/constants file: OP_BEQ=6'b000100, OP_BNE=6'b000101, BHT_WEAK_NT=2'b01.
- One sub-module: bht_2bit (counter array, two combinational read ports, two saturating write ports, async active-low reset).
- Next-PC mux and target adders stay in fetch_predict.

Test Plan:
- Reset with RESET_PC=0, imem holds two ALU ops: imem_addr goes 0, 8, 16 on successive cycles; predict_takenF=00.
- beq at PC 0x10, imm=3, counter forced 2'b10: predict_takenF=01; instrF2=0; next PC=0x20.
- From the previous state, decode returns misspredict1=1, pcsrcD1=0, pcplus4D=0x14: next PC=0x14; counter becomes 2'b01.
- stallF=1 for 3 cycles with no redirect: imem_addr and outputs held. Add jumpD1=1, jumpdstD1=28'h0000100, pcplus4D=0x14: PC=0x100 despite stallF.
- Slot 2 bne at 0x24, counter 2'b11, slot 1 not a branch: predict_takenF=10; next PC = 0x24 + (imm<<2). Four consecutive taken resolutions keep the counter at 2'b11.
- stallD=1 with misspredict1=1: no redirect, no BHT change; PC advances normally.

Source files
------------

// File: rtl/fetch_predict_pkg.sv
// Shared constants, types and helpers for the dual-issue fetch stage.
package fetch_predict_pkg;

  localparam logic [5:0]  OP_BEQ      = 6'b000100;
  localparam logic [5:0]  OP_BNE      = 6'b000101;
  localparam logic [1:0]  BHT_WEAK_NT = 2'b01;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;

  // Next-PC sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    PC_MISP1,
    PC_MISP2,
    PC_JUMP1,
    PC_JUMP2,
    PC_HOLD,
    PC_PRED1,
    PC_PRED2,
    PC_SEQ
  } pc_sel_e;

  // True for the conditional branches the BHT predicts (beq/bne).
  function automatic logic is_cond_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

  // Branch target relative to PC+4, same form as the decode-stage adders.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  // 2-bit saturating counter step.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr,
                                            input logic       taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != 2'b11)) begin
      nxt = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: 2**IDX_BITS two-bit saturating counters with two
// combinational prediction read ports and two update ports.
module bht_2bit
  import fetch_predict_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx1,
  input  logic [IDX_BITS-1:0] rd_idx2,
  output logic                rd_taken1,
  output logic                rd_taken2,
  input  logic                wr_en1,
  input  logic [IDX_BITS-1:0] wr_idx1,
  input  logic                wr_taken1,
  input  logic                wr_en2,
  input  logic [IDX_BITS-1:0] wr_idx2,
  input  logic                wr_taken2
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  // Prediction is the counter MSB, read from current state only.
  assign rd_taken1 = ctr_q[rd_idx1][1];
  assign rd_taken2 = ctr_q[rd_idx2][1];

  // Next counter state; slot 2 is applied last so it wins on an index clash.
  always_comb begin
    // NOTE: every entry gets a default first so no path leaves ctr_d unassigned (no latches).
    ctr_d = ctr_q;
    if (wr_en1) begin
      ctr_d[wr_idx1] = sat_update(ctr_q[wr_idx1], wr_taken1);
    end
    if (wr_en2) begin
      ctr_d[wr_idx2] = sat_update(ctr_q[wr_idx2], wr_taken2);
    end
  end

  // Counter array register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is built from flops, not RAM, because every counter must
      // come out of reset weakly not-taken; non-blocking keeps all updates in step.
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_WEAK_NT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// Dual-issue fetch stage: PC register, two-slot fetch, BHT-based beq/bne
// prediction and redirect handling from decode.
module fetch_predict
  import fetch_predict_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd1,
  input  logic [31:0] imem_rd2,
  output logic [31:0] instrF1,
  output logic [31:0] instrF2,
  output logic [31:0] PCPlus4F,
  output logic [1:0]  predict_takenF,
  input  logic        misspredict1,
  input  logic        misspredict2,
  input  logic        pcsrcD1,
  input  logic        pcsrcD2,
  input  logic [1:0]  branchD1,
  input  logic [1:0]  branchD2,
  input  logic [31:0] pcbranchD1,
  input  logic [31:0] pcbranchD2,
  input  logic [31:0] pcplus4D,
  input  logic        jumpD1,
  input  logic        jumpD2,
  input  logic [27:0] jumpdstD1,
  input  logic [27:0] jumpdstD2,
  input  logic        stallD
);

  logic [31:0]         pc_q, pc_d;
  logic [31:0]         pc_plus4;
  logic [31:0]         target1, target2;
  logic                branch1, branch2;
  logic                bht_taken1, bht_taken2;
  logic                p1, p2;
  logic [IDX_BITS-1:0] upd_idx1, upd_idx2;
  pc_sel_e             pc_sel;

  assign pc_plus4 = pc_q + 32'd4;

  // Prediction: slot 2 is only predicted taken when slot 1 is not.
  assign branch1 = is_cond_branch(imem_rd1[31:26]);
  assign branch2 = is_cond_branch(imem_rd2[31:26]);
  assign p1      = branch1 && bht_taken1;
  assign p2      = branch2 && bht_taken2 && !p1;

  // Both slots add to PC+4 of slot 1, mirroring the decode target adders.
  assign target1 = branch_target(pc_plus4, imem_rd1[15:0]);
  assign target2 = branch_target(pc_plus4, imem_rd2[15:0]);

  // Decode-side update indices: slot 1 sits at pcplus4D-4, slot 2 at pcplus4D.
  // Subtracting 4 only touches bits [31:2], so slot 1 is the slot-2 index minus one.
  assign upd_idx2 = pcplus4D[IDX_BITS+1:2];
  assign upd_idx1 = upd_idx2 - IDX_BITS'(1);

  bht_2bit #(
    .IDX_BITS (IDX_BITS)
  ) u_bht (
    .clk       (clk),
    .rst_n     (reset),
    .rd_idx1   (pc_q[IDX_BITS+1:2]),
    .rd_idx2   (pc_plus4[IDX_BITS+1:2]),
    .rd_taken1 (bht_taken1),
    .rd_taken2 (bht_taken2),
    .wr_en1    ((branchD1 != 2'b00) && !stallD),
    .wr_idx1   (upd_idx1),
    .wr_taken1 (pcsrcD1),
    .wr_en2    ((branchD2 != 2'b00) && !stallD),
    .wr_idx2   (upd_idx2),
    .wr_taken2 (pcsrcD2)
  );

  // Fetch outputs; a predicted-taken slot 1 squashes slot 2 to a nop.
  always_comb begin
    imem_addr      = pc_q;
    PCPlus4F       = pc_plus4;
    predict_takenF = {p2, p1};
    instrF1        = imem_rd1;
    instrF2        = p1 ? INSTR_NOP : imem_rd2;
  end

  // Next-PC source select; decode redirects beat a fetch stall.
  always_comb begin
    pc_sel = PC_SEQ;
    if (misspredict1 && !stallD) begin
      pc_sel = PC_MISP1;
    end else if (misspredict2 && !stallD) begin
      pc_sel = PC_MISP2;
    end else if (jumpD1 && !stallD) begin
      pc_sel = PC_JUMP1;
    end else if (jumpD2 && !stallD) begin
      pc_sel = PC_JUMP2;
    end else if (stallF) begin
      pc_sel = PC_HOLD;
    end else if (p1) begin
      pc_sel = PC_PRED1;
    end else if (p2) begin
      pc_sel = PC_PRED2;
    end
  end

  // Next-PC value for the selected source; all arithmetic wraps modulo 2**32.
  always_comb begin
    pc_d = pc_q + 32'd8;
    case (pc_sel)
      PC_MISP1: pc_d = pcsrcD1 ? pcbranchD1 : pcplus4D;
      PC_MISP2: pc_d = pcsrcD2 ? pcbranchD2 : (pcplus4D + 32'd4);
      PC_JUMP1: pc_d = {pcplus4D[31:28], jumpdstD1};
      PC_JUMP2: pc_d = {pcplus4D[31:28], jumpdstD2};
      PC_HOLD:  pc_d = pc_q;
      PC_PRED1: pc_d = target1;
      PC_PRED2: pc_d = target2;
      default:  pc_d = pc_q + 32'd8;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: expected fetch results are queued when a
// step is driven and compared against the DUT at the following falling edge.
module tb_fetch_predict;

  logic        clk;
  logic        reset;
  logic        stallF;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd1, imem_rd2;
  logic [31:0] instrF1, instrF2;
  logic [31:0] PCPlus4F;
  logic [1:0]  predict_takenF;
  logic        misspredict1, misspredict2;
  logic        pcsrcD1, pcsrcD2;
  logic [1:0]  branchD1, branchD2;
  logic [31:0] pcbranchD1, pcbranchD2, pcplus4D;
  logic        jumpD1, jumpD2;
  logic [27:0] jumpdstD1, jumpdstD2;
  logic        stallD;

  int errors = 0;
  int checks = 0;

  // Instruction memory model: 256 words, address bits [9:2].
  logic [31:0] mem [256];
  logic [31:0] addr2;
  assign addr2    = imem_addr + 32'd4;
  assign imem_rd1 = mem[imem_addr[9:2]];
  assign imem_rd2 = mem[addr2[9:2]];

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [1:0]  pred;
    logic [31:0] i1;
    logic [31:0] i2;
  } exp_t;

  exp_t exp_q[$];

  fetch_predict dut (
    .clk            (clk),
    .reset          (reset),
    .stallF         (stallF),
    .imem_addr      (imem_addr),
    .imem_rd1       (imem_rd1),
    .imem_rd2       (imem_rd2),
    .instrF1        (instrF1),
    .instrF2        (instrF2),
    .PCPlus4F       (PCPlus4F),
    .predict_takenF (predict_takenF),
    .misspredict1   (misspredict1),
    .misspredict2   (misspredict2),
    .pcsrcD1        (pcsrcD1),
    .pcsrcD2        (pcsrcD2),
    .branchD1       (branchD1),
    .branchD2       (branchD2),
    .pcbranchD1     (pcbranchD1),
    .pcbranchD2     (pcbranchD2),
    .pcplus4D       (pcplus4D),
    .jumpD1         (jumpD1),
    .jumpD2         (jumpD2),
    .jumpdstD1      (jumpdstD1),
    .jumpdstD2      (jumpdstD2),
    .stallD         (stallD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the expected fetch view for a given slot-1 PC and prediction.
  task automatic push_exp(input string tag, input logic [31:0] addr, input logic [1:0] pred);
    exp_t        e;
    logic [31:0] a2;
    a2     = addr + 32'd4;
    e.tag  = tag;
    e.addr = addr;
    e.pred = pred;
    e.i1   = mem[addr[9:2]];
    e.i2   = pred[0] ? 32'h0 : mem[a2[9:2]];
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".addr"},  imem_addr, e.addr);
    check({e.tag, ".pc4"},   PCPlus4F, e.addr + 32'd4);
    check({e.tag, ".pred"},  {30'd0, predict_takenF}, {30'd0, e.pred});
    check({e.tag, ".instr1"}, instrF1, e.i1);
    check({e.tag, ".instr2"}, instrF2, e.i2);
  endtask

  task automatic idle();
    stallF       = 1'b0;
    misspredict1 = 1'b0;
    misspredict2 = 1'b0;
    pcsrcD1      = 1'b0;
    pcsrcD2      = 1'b0;
    branchD1     = 2'b00;
    branchD2     = 2'b00;
    pcbranchD1   = 32'h0;
    pcbranchD2   = 32'h0;
    pcplus4D     = 32'h0;
    jumpD1       = 1'b0;
    jumpD2       = 1'b0;
    jumpdstD1    = 28'h0;
    jumpdstD2    = 28'h0;
    stallD       = 1'b0;
  endtask

  // One clock edge with the currently driven inputs, then compare.
  task automatic step(input string tag, input logic [31:0] addr, input logic [1:0] pred);
    push_exp(tag, addr, pred);
    @(negedge clk);
    idle();
    pop_check();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0000_0020 | (32'(i) << 16);
    end
    mem[4] = 32'h1000_0003;  // 0x10: beq, imm 3  -> target 0x20
    mem[9] = 32'h1400_0005;  // 0x24: bne, imm 5  -> target 0x38 from PC 0x20
    idle();

    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    push_exp("in_reset", 32'h0, 2'b00);
    pop_check();

    @(negedge clk);
    reset = 1'b1;
    push_exp("reset_pc", 32'h0, 2'b00);
    pop_check();

    step("seq8", 32'h08, 2'b00);
    step("seq16", 32'h10, 2'b00);

    branchD1 = 2'b01; pcsrcD1 = 1'b1; pcplus4D = 32'h14;
    step("train_beq", 32'h18, 2'b00);

    jumpD1 = 1'b1; jumpdstD1 = 28'h0000010; pcplus4D = 32'h1C;
    step("beq_pred", 32'h10, 2'b01);

    step("beq_target", 32'h20, 2'b00);

    misspredict1 = 1'b1; pcsrcD1 = 1'b0; branchD1 = 2'b01; pcplus4D = 32'h14;
    step("misp1_nt", 32'h14, 2'b00);

    for (int i = 0; i < 3; i++) begin
      stallF = 1'b1;
      step($sformatf("stallF%0d", i), 32'h14, 2'b00);
    end

    stallF = 1'b1; jumpD1 = 1'b1; jumpdstD1 = 28'h0000100; pcplus4D = 32'h14;
    step("jump_over_stall", 32'h100, 2'b00);

    jumpD1 = 1'b1; jumpdstD1 = 28'h0000010; pcplus4D = 32'h104;
    step("beq_ctr_back_01", 32'h10, 2'b00);

    branchD2 = 2'b10; pcsrcD2 = 1'b1; pcplus4D = 32'h24;
    step("train_bne_a", 32'h18, 2'b00);
    branchD2 = 2'b10; pcsrcD2 = 1'b1; pcplus4D = 32'h24;
    step("bne_pred", 32'h20, 2'b10);

    for (int i = 0; i < 4; i++) begin
      branchD2 = 2'b01; pcsrcD2 = 1'b1; pcplus4D = 32'h24;
      step($sformatf("sat_taken%0d", i), 32'h38 + 32'(8 * i), 2'b00);
    end

    jumpD1 = 1'b1; jumpdstD1 = 28'h0000020; pcplus4D = 32'h54;
    step("bne_sat_pred", 32'h20, 2'b10);

    for (int i = 0; i < 2; i++) begin
      stallD = 1'b1; misspredict1 = 1'b1; pcsrcD1 = 1'b1; pcbranchD1 = 32'h200;
      branchD1 = 2'b01; branchD2 = 2'b10; pcsrcD2 = 1'b0; pcplus4D = 32'h24;
      step($sformatf("stallD%0d", i), (i == 0) ? 32'h38 : 32'h40, 2'b00);
    end

    jumpD1 = 1'b1; jumpdstD1 = 28'h0000020; pcplus4D = 32'h44;
    step("bht_kept_under_stallD", 32'h20, 2'b10);

    misspredict2 = 1'b1; pcsrcD2 = 1'b0; pcplus4D = 32'h60;
    jumpD1 = 1'b1; jumpdstD1 = 28'h0000300;
    step("misp2_nt", 32'h64, 2'b00);

    misspredict1 = 1'b1; pcsrcD1 = 1'b1; pcbranchD1 = 32'h80;
    misspredict2 = 1'b1; pcsrcD2 = 1'b1; pcbranchD2 = 32'h90;
    step("misp1_priority", 32'h80, 2'b00);

    misspredict2 = 1'b1; pcsrcD2 = 1'b1; pcbranchD2 = 32'h90;
    jumpD1 = 1'b1; jumpdstD1 = 28'h0000300;
    step("misp2_taken", 32'h90, 2'b00);

    jumpD2 = 1'b1; jumpdstD2 = 28'hFFF_FFF8; pcplus4D = 32'hF000_0000;
    step("jump2_high", 32'hFFFF_FFF8, 2'b00);

    step("pc_wrap", 32'h0, 2'b00);
    step("after_wrap", 32'h08, 2'b00);
    step("walk10", 32'h10, 2'b00);
    step("walk18", 32'h18, 2'b00);
    step("walk20", 32'h20, 2'b10);

    #2 reset = 1'b0;
    #1;
    push_exp("midrun_reset", 32'h0, 2'b00);
    pop_check();
    @(negedge clk);
    reset = 1'b1;
    push_exp("post_reset_pc", 32'h0, 2'b00);
    pop_check();

    step("post_reset8", 32'h08, 2'b00);
    step("post_reset10", 32'h10, 2'b00);
    step("post_reset18", 32'h18, 2'b00);
    step("post_reset_bht", 32'h20, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
